// File: rtl/regfile_write_sched.sv
// Register-file write scheduler: arbitrates rename requests against buffered ROB commits.
// Optional perf counters are enabled with `define REGSCHED_PERF_EN.
module regfile_write_sched #(
    parameter int unsigned CMT_DEPTH = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [4:0]       iss_rd,
    input  logic [3:0]       iss_rob,
    input  logic             cmt_valid,
    output logic             cmt_ready,
    input  logic [4:0]       cmt_rd,
    input  logic [3:0]       cmt_rob,
    input  logic [31:0]      cmt_val,
    output logic             rd_in_flag,
    output logic [4:0]       rd_in_a,
    output logic [3:0]       rd_in_rob,
    output logic             rd_out_flag,
    output logic [4:0]       rd_out_a,
    output logic [3:0]       rd_out_rob,
    output logic [31:0]      rd_out_val,
`ifdef REGSCHED_PERF_EN
    output logic [31:0]      perf_iss_stall,
    output logic [31:0]      perf_cmt_full,
`endif
    output logic [CNT_W-1:0] cmt_count,
    output logic             busy
);

    localparam int unsigned PTR_W = (CMT_DEPTH > 1) ? $clog2(CMT_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CMT_DEPTH);

    typedef enum logic {
        GNT_ISSUE = 1'b0,
        GNT_CMT   = 1'b1
    } gnt_e;

    logic [4:0]       r_q_rd  [CMT_DEPTH];
    logic [3:0]       r_q_rob [CMT_DEPTH];
    logic [31:0]      r_q_val [CMT_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    gnt_e             r_last_gnt;

    logic             r_in_flag;
    logic [4:0]       r_in_a;
    logic [3:0]       r_in_rob;
    logic             r_out_flag;
    logic [4:0]       r_out_a;
    logic [3:0]       r_out_rob;
    logic [31:0]      r_out_val;

    logic w_full;
    logic w_cmt_ready;
    logic w_enq;
    logic w_store;
    logic w_iss_req;
    logic w_cmt_req;
    logic w_contend;
    logic w_cmt_gnt;
    logic w_iss_gnt;
    logic w_iss_ready;

    assign w_full      = (r_count == DEPTH_C);
    assign w_cmt_ready = rdy && (r_count < DEPTH_C);
    assign w_enq       = cmt_valid && w_cmt_ready;
    assign w_store     = w_enq && (cmt_rd != 5'd0);

    // Commit request looks only at pre-enqueue occupancy; no same-cycle bypass.
    assign w_iss_req = iss_valid && !flush && (iss_rd != 5'd0);
    assign w_cmt_req = (r_count != '0);
    assign w_contend = w_iss_req && w_cmt_req;

    assign w_cmt_gnt = rdy && w_cmt_req &&
                       (!w_iss_req || w_full || (r_last_gnt == GNT_ISSUE));
    assign w_iss_gnt = rdy && w_iss_req && !w_cmt_gnt;

    assign w_iss_ready = rdy && !flush && ((iss_rd == 5'd0) || w_iss_gnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last_gnt <= GNT_ISSUE;
            r_in_flag  <= 1'b0;
            r_in_a     <= '0;
            r_in_rob   <= '0;
            r_out_flag <= 1'b0;
            r_out_a    <= '0;
            r_out_rob  <= '0;
            r_out_val  <= '0;
        end else if (rdy) begin
            if (w_store) begin
                r_q_rd[r_wr_ptr]  <= cmt_rd;
                r_q_rob[r_wr_ptr] <= cmt_rob;
                r_q_val[r_wr_ptr] <= cmt_val;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_cmt_gnt) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_store, w_cmt_gnt})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A full-FIFO forced commit does not count as a round-robin turn.
            if (w_contend && !w_full) begin
                r_last_gnt <= w_cmt_gnt ? GNT_CMT : GNT_ISSUE;
            end
            r_in_flag <= w_iss_gnt;
            if (w_iss_gnt) begin
                r_in_a   <= iss_rd;
                r_in_rob <= iss_rob;
            end
            r_out_flag <= w_cmt_gnt;
            if (w_cmt_gnt) begin
                r_out_a   <= r_q_rd[r_rd_ptr];
                r_out_rob <= r_q_rob[r_rd_ptr];
                r_out_val <= r_q_val[r_rd_ptr];
            end
        end else begin
            r_in_flag  <= 1'b0;
            r_out_flag <= 1'b0;
        end
    end

`ifdef REGSCHED_PERF_EN
    logic [31:0] r_perf_iss_stall;
    logic [31:0] r_perf_cmt_full;
    logic        w_iss_stall;
    logic        w_cmt_stall;

    assign w_iss_stall = rdy && iss_valid && !flush && !w_iss_ready;
    assign w_cmt_stall = rdy && cmt_valid && !w_cmt_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_iss_stall <= '0;
            r_perf_cmt_full  <= '0;
        end else begin
            if (w_iss_stall && (r_perf_iss_stall != '1)) begin
                r_perf_iss_stall <= r_perf_iss_stall + 32'd1;
            end
            if (w_cmt_stall && (r_perf_cmt_full != '1)) begin
                r_perf_cmt_full <= r_perf_cmt_full + 32'd1;
            end
        end
    end

    assign perf_iss_stall = r_perf_iss_stall;
    assign perf_cmt_full  = r_perf_cmt_full;
`endif

    assign iss_ready   = w_iss_ready;
    assign cmt_ready   = w_cmt_ready;
    assign rd_in_flag  = r_in_flag;
    assign rd_in_a     = r_in_a;
    assign rd_in_rob   = r_in_rob;
    assign rd_out_flag = r_out_flag;
    assign rd_out_a    = r_out_a;
    assign rd_out_rob  = r_out_rob;
    assign rd_out_val  = r_out_val;
    assign cmt_count   = r_count;
    assign busy        = (r_count != '0);

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed self-checking bench for regfile_write_sched (default depth 4).
module tb_regfile_write_sched;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_rd;
    logic [3:0]  iss_rob;
    logic        cmt_valid;
    logic        cmt_ready;
    logic [4:0]  cmt_rd;
    logic [3:0]  cmt_rob;
    logic [31:0] cmt_val;
    logic        rd_in_flag;
    logic [4:0]  rd_in_a;
    logic [3:0]  rd_in_rob;
    logic        rd_out_flag;
    logic [4:0]  rd_out_a;
    logic [3:0]  rd_out_rob;
    logic [31:0] rd_out_val;
    logic [2:0]  cmt_count;
    logic        busy;
`ifdef REGSCHED_PERF_EN
    logic [31:0] perf_iss_stall;
    logic [31:0] perf_cmt_full;
`endif

    int n_checks = 0;
    int n_errors = 0;

    regfile_write_sched #(.CMT_DEPTH(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .flush       (flush),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_rd      (iss_rd),
        .iss_rob     (iss_rob),
        .cmt_valid   (cmt_valid),
        .cmt_ready   (cmt_ready),
        .cmt_rd      (cmt_rd),
        .cmt_rob     (cmt_rob),
        .cmt_val     (cmt_val),
        .rd_in_flag  (rd_in_flag),
        .rd_in_a     (rd_in_a),
        .rd_in_rob   (rd_in_rob),
        .rd_out_flag (rd_out_flag),
        .rd_out_a    (rd_out_a),
        .rd_out_rob  (rd_out_rob),
        .rd_out_val  (rd_out_val),
`ifdef REGSCHED_PERF_EN
        .perf_iss_stall (perf_iss_stall),
        .perf_cmt_full  (perf_cmt_full),
`endif
        .cmt_count   (cmt_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        iss_rd    = '0;
        iss_rob   = '0;
        cmt_valid = 1'b0;
        cmt_rd    = '0;
        cmt_rob   = '0;
        cmt_val   = '0;
        flush     = 1'b0;
    endtask

    // Issue rd=10 held valid; three commits offered. From last_gnt=ISSUE and empty
    // FIFO this yields: rename, commit(base), rename, leaving 2 entries buffered.
    task automatic prime(input string tag, input logic [4:0] base_rd, input logic [31:0] base_val);
        for (int i = 0; i < 3; i++) begin
            iss_valid = 1'b1;
            iss_rd    = 5'd10;
            iss_rob   = 4'(i);
            cmt_valid = 1'b1;
            cmt_rd    = base_rd + 5'(i);
            cmt_rob   = 4'(i);
            cmt_val   = base_val + 32'(i);
            tick();
        end
        check({tag, "_prime_cnt"}, 32'(cmt_count), 32'd2);
        check({tag, "_prime_in"},  32'(rd_in_flag), 32'd1);
    endtask

    // Round-robin table: issue held for 7 cycles, commits offered in the first 3.
    int rr_iready [7] = '{1, 0, 1, 0, 1, 0, 1};
    int rr_in     [7] = '{1, 0, 1, 0, 1, 0, 1};
    int rr_out_rd [7] = '{0, 1, 0, 2, 0, 3, 0};
    int rr_cnt    [7] = '{1, 1, 2, 1, 1, 0, 0};

    // Fill table: issue and commits both held for 7 cycles.
    int fl_iready [7] = '{1, 1, 0, 1, 0, 1, 0};
    int fl_cready [7] = '{1, 1, 1, 1, 1, 1, 0};
    int fl_in     [7] = '{1, 1, 0, 1, 0, 1, 0};
    int fl_out_rd [7] = '{0, 0, 1, 0, 2, 0, 3};
    int fl_cnt    [7] = '{1, 2, 2, 3, 3, 4, 3};

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        idle();
        tick();
        tick();
        check("rst_in_flag",  32'(rd_in_flag),  32'd0);
        check("rst_out_flag", 32'(rd_out_flag), 32'd0);
        check("rst_count",    32'(cmt_count),   32'd0);
        check("rst_busy",     32'(busy),        32'd0);
        check("rst_out_val",  rd_out_val,       32'd0);
        rst = 1'b0;

        // Single rename
        iss_valid = 1'b1; iss_rd = 5'd5; iss_rob = 4'd3;
        #1;
        check("ren_iss_ready", 32'(iss_ready), 32'd1);
        tick();
        idle();
        check("ren_in_flag",  32'(rd_in_flag),  32'd1);
        check("ren_in_a",     32'(rd_in_a),     32'd5);
        check("ren_in_rob",   32'(rd_in_rob),   32'd3);
        check("ren_out_flag", 32'(rd_out_flag), 32'd0);
        tick();
        check("ren_in_clear", 32'(rd_in_flag), 32'd0);

        // Commit only
        cmt_valid = 1'b1; cmt_rd = 5'd7; cmt_rob = 4'd2; cmt_val = 32'hDEADBEEF;
        #1;
        check("cmt_ready", 32'(cmt_ready), 32'd1);
        tick();
        idle();
        check("cmt_e1_count", 32'(cmt_count),   32'd1);
        check("cmt_e1_busy",  32'(busy),        32'd1);
        check("cmt_e1_out",   32'(rd_out_flag), 32'd0);
        tick();
        check("cmt_e2_out",   32'(rd_out_flag), 32'd1);
        check("cmt_e2_a",     32'(rd_out_a),    32'd7);
        check("cmt_e2_rob",   32'(rd_out_rob),  32'd2);
        check("cmt_e2_val",   rd_out_val,       32'hDEADBEEF);
        check("cmt_e2_in",    32'(rd_in_flag),  32'd0);
        check("cmt_e2_count", 32'(cmt_count),   32'd0);
        tick();
        check("cmt_e3_out",   32'(rd_out_flag), 32'd0);

        // rdy low freezes everything
        rdy = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd9; iss_rob = 4'd9;
        cmt_valid = 1'b1; cmt_rd = 5'd9; cmt_val = 32'h9;
        #1;
        check("frz_iss_ready", 32'(iss_ready), 32'd0);
        check("frz_cmt_ready", 32'(cmt_ready), 32'd0);
        tick();
        check("frz_count", 32'(cmt_count),  32'd0);
        check("frz_in",    32'(rd_in_flag), 32'd0);
        check("frz_in_a",  32'(rd_in_a),    32'd5);
        check("frz_out_a", 32'(rd_out_a),   32'd7);
        rdy = 1'b1;
        idle();

        // Contention round-robin
        for (int i = 0; i < 7; i++) begin
            iss_valid = 1'b1; iss_rd = 5'd10; iss_rob = 4'(i);
            cmt_valid = (i < 3); cmt_rd = 5'(i + 1); cmt_rob = 4'(i); cmt_val = 32'h100 + 32'(i);
            #1;
            check($sformatf("rr%0d_iss_ready", i), 32'(iss_ready), 32'(rr_iready[i]));
            tick();
            check($sformatf("rr%0d_in", i),  32'(rd_in_flag),  32'(rr_in[i]));
            check($sformatf("rr%0d_out", i), 32'(rd_out_flag), 32'(rr_out_rd[i] != 0));
            if (rr_out_rd[i] != 0) begin
                check($sformatf("rr%0d_out_a", i),   32'(rd_out_a), 32'(rr_out_rd[i]));
                check($sformatf("rr%0d_out_val", i), rd_out_val,    32'h100 + 32'(rr_out_rd[i] - 1));
            end
            check($sformatf("rr%0d_cnt", i), 32'(cmt_count), 32'(rr_cnt[i]));
        end
        idle();
        tick();

        // Fill to full while issue is held valid
        for (int i = 0; i < 7; i++) begin
            iss_valid = 1'b1; iss_rd = 5'd10; iss_rob = 4'(i);
            cmt_valid = 1'b1; cmt_rd = 5'(i + 1); cmt_rob = 4'(i); cmt_val = 32'hA0 + 32'(i);
            #1;
            check($sformatf("fl%0d_iss_ready", i), 32'(iss_ready), 32'(fl_iready[i]));
            check($sformatf("fl%0d_cmt_ready", i), 32'(cmt_ready), 32'(fl_cready[i]));
            tick();
            check($sformatf("fl%0d_in", i),  32'(rd_in_flag),  32'(fl_in[i]));
            check($sformatf("fl%0d_out", i), 32'(rd_out_flag), 32'(fl_out_rd[i] != 0));
            if (fl_out_rd[i] != 0) begin
                check($sformatf("fl%0d_out_a", i),   32'(rd_out_a), 32'(fl_out_rd[i]));
                check($sformatf("fl%0d_out_val", i), rd_out_val,    32'hA0 + 32'(fl_out_rd[i] - 1));
            end
            check($sformatf("fl%0d_cnt", i), 32'(cmt_count), 32'(fl_cnt[i]));
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("dr%0d_out", i),     32'(rd_out_flag), 32'd1);
            check($sformatf("dr%0d_out_a", i),   32'(rd_out_a),    32'(4 + i));
            check($sformatf("dr%0d_out_val", i), rd_out_val,       32'hA3 + 32'(i));
            check($sformatf("dr%0d_cnt", i),     32'(cmt_count),   32'(2 - i));
        end
        tick();

        // x0 filtering
        iss_valid = 1'b1; iss_rd = 5'd0;
        cmt_valid = 1'b1; cmt_rd = 5'd0; cmt_val = 32'h55;
        #1;
        check("x0_iss_ready", 32'(iss_ready), 32'd1);
        check("x0_cmt_ready", 32'(cmt_ready), 32'd1);
        tick();
        idle();
        check("x0_in",  32'(rd_in_flag),  32'd0);
        check("x0_out", 32'(rd_out_flag), 32'd0);
        check("x0_cnt", 32'(cmt_count),   32'd0);
        tick();
        check("x0_out_late", 32'(rd_out_flag), 32'd0);

        // Flush with two commits buffered
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prime("fl", 5'd20, 32'h200);
        for (int i = 0; i < 2; i++) begin
            idle();
            flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd10;
            #1;
            check($sformatf("fsh%0d_iss_ready", i), 32'(iss_ready), 32'd0);
            tick();
            check($sformatf("fsh%0d_out", i),     32'(rd_out_flag), 32'd1);
            check($sformatf("fsh%0d_out_a", i),   32'(rd_out_a),    32'd21 + 32'(i));
            check($sformatf("fsh%0d_out_val", i), rd_out_val,       32'h201 + 32'(i));
            check($sformatf("fsh%0d_in", i),      32'(rd_in_flag),  32'd0);
        end
        idle();
        check("fsh_cnt", 32'(cmt_count), 32'd0);

        // Reset mid-drain
        prime("rs", 5'd24, 32'h300);
        idle();
        tick();
        check("rs_drain_out", 32'(rd_out_flag), 32'd1);
        check("rs_drain_cnt", 32'(cmt_count),   32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_out",   32'(rd_out_flag), 32'd0);
        check("rs_in",    32'(rd_in_flag),  32'd0);
        check("rs_cnt",   32'(cmt_count),   32'd0);
        check("rs_busy",  32'(busy),        32'd0);
        check("rs_out_a", 32'(rd_out_a),    32'd0);
        tick();
        check("rs_no_drain", 32'(rd_out_flag), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
